// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller slice.
//   state_t            - access FSM encoding (IDLE, LO, HI, DONE)
//   DEFAULT_BASE_ADDR  - default data-memory base subtracted from CPU addresses
//   SRAM_DW / SRAM_AW  - external SRAM data and half-word address widths
package sram_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
   localparam int unsigned SRAM_DW           = 16;
   localparam int unsigned SRAM_AW           = 18;

endpackage

// File: rtl/sram_controller_wait_counter.sv
// Per-phase wait-state counter.
//   clk, rst - clock and synchronous active-high reset
//   clr      - restart the count at 0 (takes priority over en)
//   en       - advance the count by one
//   tc       - high while the count equals SRAM_WAIT (last cycle of a phase)
module sram_controller_wait_counter #(
   parameter int unsigned SRAM_WAIT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [2:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 3'd1;
      end
   end

   assign tc = (count == 3'(SRAM_WAIT));

endmodule

// File: rtl/sram_controller.sv
// 32-bit MEM-stage load/store to a 16-bit asynchronous SRAM, done as two
// half-word phases (LO then HI) of SRAM_WAIT+1 cycles each.
//   clk, rst          - clock, synchronous active-high reset
//   wr_en, rd_en      - store / load request, held until ready
//   address           - byte address; BASE_ADDR is subtracted, word aligned
//   write_data        - store data
//   read_data         - assembled load word, held until the next load
//   ready             - low stalls the pipeline while an access is pending
//   sram_dq           - bidirectional SRAM data bus
//   sram_addr         - SRAM half-word address
//   sram_*_n          - active-low SRAM strobes
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int unsigned SRAM_WAIT = 2,
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic                 rd_en,
   input  logic [31:0]          address,
   input  logic [31:0]          write_data,
   output logic [31:0]          read_data,
   output logic                 ready,
   inout  wire  [SRAM_DW-1:0]   sram_dq,
   output logic [SRAM_AW-1:0]   sram_addr,
   output logic                 sram_we_n,
   output logic                 sram_oe_n,
   output logic                 sram_ce_n,
   output logic                 sram_ub_n,
   output logic                 sram_lb_n
);

   state_t               state;
   logic                 is_write;
   logic [SRAM_AW-2:0]   word_addr;
   logic [SRAM_DW-1:0]   wdata_hi;
   logic [SRAM_DW-1:0]   dq_out;
   logic                 dq_oe;
   logic                 req;
   logic                 in_phase;
   logic                 cnt_clr;
   logic                 tc;
   logic [31:0]          offset;
   logic                 unused_offset_bits;

   assign req      = rd_en | wr_en;
   assign offset   = address - BASE_ADDR;
   assign in_phase = (state == ST_LO) || (state == ST_HI);

   // Byte-lane bits and everything above the 512 KB window are discarded.
   assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

   // Counter restarts on every phase entry (IDLE->LO, LO->HI) and on HI->DONE.
   assign cnt_clr = ((state == ST_IDLE) && req) || (in_phase && tc);

   assign ready   = ~req | (state == ST_DONE);
   assign sram_dq = dq_oe ? dq_out : 'z;

   sram_controller_wait_counter #(
      .SRAM_WAIT (SRAM_WAIT)
   ) wait_counter (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (in_phase),
      .tc  (tc)
   );

   // Pin outputs are registered alongside the state so each strobe changes
   // on the same edge as the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         is_write  <= 1'b0;
         word_addr <= '0;
         wdata_hi  <= '0;
         dq_out    <= '0;
         dq_oe     <= 1'b0;
         read_data <= '0;
         sram_addr <= '0;
         sram_we_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_ce_n <= 1'b1;
         sram_ub_n <= 1'b1;
         sram_lb_n <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  // Write wins when both requests are raised together.
                  state     <= ST_LO;
                  is_write  <= wr_en;
                  word_addr <= offset[18:2];
                  wdata_hi  <= write_data[31:16];
                  dq_out    <= write_data[15:0];
                  dq_oe     <= wr_en;
                  sram_addr <= {offset[18:2], 1'b0};
                  sram_we_n <= ~wr_en;
                  sram_oe_n <= wr_en;
                  sram_ce_n <= 1'b0;
                  sram_ub_n <= 1'b0;
                  sram_lb_n <= 1'b0;
               end
            end
            ST_LO: begin
               if (tc) begin
                  state     <= ST_HI;
                  sram_addr <= {word_addr, 1'b1};
                  dq_out    <= wdata_hi;
                  if (!is_write) begin
                     read_data[15:0] <= sram_dq;
                  end
               end
            end
            ST_HI: begin
               if (tc) begin
                  state     <= ST_DONE;
                  dq_oe     <= 1'b0;
                  sram_addr <= '0;
                  sram_we_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  sram_ce_n <= 1'b1;
                  sram_ub_n <= 1'b1;
                  sram_lb_n <= 1'b1;
                  if (!is_write) begin
                     read_data[31:16] <= sram_dq;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Behavioural 256K x 16 asynchronous SRAM: zero-latency reads; a write lands
// only after the same address has been held with we_n low for TWC edges.
module sram_model #(
   parameter int unsigned TWC  = 3,
   parameter logic [15:0] SEED = 16'h5A00
) (
   input  logic        clk,
   inout  wire  [15:0] dq,
   input  logic [17:0] addr,
   input  logic        we_n,
   input  logic        oe_n,
   input  logic        ce_n,
   input  logic        ub_n,
   input  logic        lb_n
);
   logic [15:0] mem [0:262143];
   logic [17:0] last_addr;
   int unsigned hold;

   initial begin
      for (int i = 0; i < 262144; i++) mem[i] = 16'(i) ^ SEED;
      hold      = 0;
      last_addr = '0;
   end

   assign dq = (!ce_n && !oe_n && we_n) ? mem[addr] : 'z;

   always @(posedge clk) begin
      if (!ce_n && !we_n && !ub_n && !lb_n) begin
         if (addr == last_addr && hold != 0) hold = hold + 1;
         else hold = 1;
         last_addr = addr;
         if (hold == TWC) mem[addr] <= dq;
      end else begin
         hold = 0;
      end
   end
endmodule

module tb_sram_controller;
   localparam int unsigned W = 2;

   typedef struct {
      logic        is_wr;
      logic [16:0] word;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, wr_en, rd_en;
   logic [31:0] address, write_data, read_data;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

   logic        wr0, rd0;
   logic [31:0] addr0, wd0, rdata0;
   logic        ready0;
   wire  [15:0] dq0;
   logic [17:0] saddr0;
   logic        we0_n, oe0_n, ce0_n, ub0_n, lb0_n;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned low_cnt = 0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   sram_controller #(.SRAM_WAIT(W), .BASE_ADDR(32'd1024)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
      .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n),
      .sram_lb_n(sram_lb_n));

   sram_model #(.TWC(W + 1), .SEED(16'h5A00)) u_mem (
      .clk(clk), .dq(sram_dq), .addr(sram_addr), .we_n(sram_we_n),
      .oe_n(sram_oe_n), .ce_n(sram_ce_n), .ub_n(sram_ub_n), .lb_n(sram_lb_n));

   sram_controller #(.SRAM_WAIT(0), .BASE_ADDR(32'd1024)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(addr0),
      .write_data(wd0), .read_data(rdata0), .ready(ready0),
      .sram_dq(dq0), .sram_addr(saddr0), .sram_we_n(we0_n),
      .sram_oe_n(oe0_n), .sram_ce_n(ce0_n), .sram_ub_n(ub0_n),
      .sram_lb_n(lb0_n));

   sram_model #(.TWC(1), .SEED(16'h5A00)) u_mem0 (
      .clk(clk), .dq(dq0), .addr(saddr0), .we_n(we0_n),
      .oe_n(oe0_n), .ce_n(ce0_n), .ub_n(ub0_n), .lb_n(lb0_n));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [22:0] pins();
      return {sram_addr, sram_ce_n, sram_ub_n, sram_lb_n, sram_we_n, sram_oe_n};
   endfunction

   // Expected pins for cycle k of a window: 1 = IDLE, then LO, then HI.
   function automatic logic [22:0] exp_pins(input int unsigned k, input exp_t e);
      if (k >= 2 && k <= W + 2)
         return {e.word, 1'b0, 3'b000, ~e.is_wr, e.is_wr};
      else if (k >= W + 3 && k <= 2 * W + 3)
         return {e.word, 1'b1, 3'b000, ~e.is_wr, e.is_wr};
      else
         return {18'd0, 5'b11111};
   endfunction

   // Monitor: checks every cycle of an outstanding access against the queue head.
   always @(negedge clk) begin
      if (rst) begin
         low_cnt = 0;
      end else if (!(rd_en || wr_en)) begin
         chk("ready_no_req", {63'd0, ready}, 64'd1);
      end else if (sb.size() != 0) begin
         mon_e = sb[0];
         if (!ready) begin
            low_cnt = low_cnt + 1;
            chk("pins", {41'd0, pins()}, {41'd0, exp_pins(low_cnt, mon_e)});
            if (mon_e.is_wr && low_cnt >= 2 && low_cnt <= W + 2)
               chk("dq_lo", {48'd0, sram_dq}, {48'd0, mon_e.wdata[15:0]});
            if (mon_e.is_wr && low_cnt >= W + 3 && low_cnt <= 2 * W + 3)
               chk("dq_hi", {48'd0, sram_dq}, {48'd0, mon_e.wdata[31:16]});
         end else begin
            chk("low_cycles", {32'd0, low_cnt}, 64'(2 * W + 3));
            chk("read_data", {32'd0, read_data}, {32'd0, mon_e.rdata});
            chk("pins_done", {41'd0, pins()}, {41'd0, 18'd0, 5'b11111});
            void'(sb.pop_front());
            low_cnt = 0;
         end
      end
   end

   task automatic access(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd,
                         input int unsigned chg_at, input logic keep);
      exp_t        e;
      logic [31:0] off;
      logic        done;
      off     = a - 32'd1024;
      e.is_wr = w;
      e.word  = off[18:2];
      e.wdata = d;
      e.rdata = exp_rd;
      sb.push_back(e);
      wr_en = w; rd_en = r; address = a; write_data = d;
      done = 1'b0;
      for (int i = 1; i <= 40 && !done; i++) begin
         @(negedge clk);
         if (ready) done = 1'b1;
         else if (i == chg_at) begin
            // Disturb the request mid-access; the latched access must not change.
            address = a ^ 32'h0000_0F0C;
            wr_en   = 1'b1;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL timeout: ready never rose for address %0h", a);
         sb.delete();
      end
      @(posedge clk); #1;
      if (!keep) begin
         wr_en = 1'b0; rd_en = 1'b0;
      end
   endtask

   initial begin
      int unsigned cnt;
      logic        done;
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
      wr0 = 1'b0; rd0 = 1'b0; addr0 = '0; wd0 = '0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_pins", {41'd0, pins()}, {41'd0, 18'd0, 5'b11111});
      chk("rst_read_data", {32'd0, read_data}, 64'd0);
      chk("rst_ready", {63'd0, ready}, 64'd1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_pins", {41'd0, pins()}, {41'd0, 18'd0, 5'b11111});
      @(posedge clk); #1;

      // Write 0xDEADBEEF @1028 -> halves 2/3.
      access(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
      chk("mem2", {48'd0, u_mem.mem[2]}, 64'hBEEF);
      chk("mem3", {48'd0, u_mem.mem[3]}, 64'hDEAD);

      // Read back, with the request disturbed on cycle 3.
      access(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);

      // Back-to-back reads: 1024 then 1032.
      access(1'b0, 1'b1, 32'd1024, 32'h0, 32'h5A01_5A00, 0, 1'b1);
      access(1'b0, 1'b1, 32'd1032, 32'h0, 32'h5A05_5A04, 0, 1'b0);

      // rd_en and wr_en together -> write; read_data keeps the last load.
      access(1'b1, 1'b1, 32'd1024, 32'h1234_5678, 32'h5A05_5A04, 0, 1'b0);
      chk("mem0", {48'd0, u_mem.mem[0]}, 64'h5678);
      chk("mem1", {48'd0, u_mem.mem[1]}, 64'h1234);

      // Reset on the 2nd HI cycle of a write to 1040 (halves 8/9).
      wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFE_F00D;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("abort_in_hi", {46'd0, sram_addr}, 64'd9);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      chk("abort_pins", {41'd0, pins()}, {41'd0, 18'd0, 5'b11111});
      chk("abort_read_data", {32'd0, read_data}, 64'd0);
      chk("abort_mem9", {48'd0, u_mem.mem[9]}, 64'h5A09);
      @(posedge clk); #1;

      // Recovery read, address wrap above 512 KB, and an address below base.
      access(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
      access(1'b0, 1'b1, 32'd525316, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
      access(1'b0, 1'b1, 32'd1020, 32'h0, 32'hA5FF_A5FE, 0, 1'b0);

      // SRAM_WAIT=0 instance: idle with no request, then a 3-cycle read.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("w0_idle_ready", {63'd0, ready0}, 64'd1);
         chk("w0_idle_ce", {63'd0, ce0_n}, 64'd1);
      end
      @(posedge clk); #1;
      rd0 = 1'b1; addr0 = 32'd1032;
      cnt = 0; done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (ready0) done = 1'b1;
         else cnt = cnt + 1;
      end
      chk("w0_low_cycles", {32'd0, cnt}, 64'd3);
      chk("w0_read_data", {32'd0, rdata0}, 64'h5A05_5A04);
      @(posedge clk); #1 rd0 = 1'b0;

      repeat (2) @(posedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
